// File: rtl/mem_stage.sv
// RV32I MEM stage: data-memory request/ready handshake, byte-lane alignment,
// load sign/zero extension, and the registered MEM/WB boundary signals.
module mem_stage #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            EX_valid,
   input  logic            EX_MemRead,
   input  logic            EX_MemWrite,
   input  logic            EX_MemtoReg,
   input  logic            EX_RegWrite,
   input  logic [2:0]      EX_funct3,
   input  logic [XLEN-1:0] EX_alu_out,
   input  logic [XLEN-1:0] EX_rs2_data,
   input  logic [4:0]      EX_rd_addr,
   output logic            DM_req,
   output logic            DM_we,
   output logic [3:0]      DM_be,
   output logic [XLEN-1:0] DM_addr,
   output logic [XLEN-1:0] DM_wdata,
   input  logic            DM_ready,
   input  logic [XLEN-1:0] DM_rdata,
   output logic            MEM_stall,
   output logic            MEM_fault,
   output logic            MEM_MemtoReg,
   output logic            MEM_RegWrite,
   output logic [XLEN-1:0] MEM_rd_data,
   output logic [XLEN-1:0] MEM_Dout,
   output logic [4:0]      MEM_rd_addr
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;
   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

   state_t          r_state, w_state_nx;
   logic [7:0]      r_wait, w_wait_nx;
   logic [1:0]      w_off;
   logic            w_mem_op, w_store, w_legal, w_misalign, w_acc_fault, w_issue;
   logic            w_req, w_stall, w_fault, w_complete, w_timeout, w_nonmem;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata, w_shifted, w_load;

   assign w_off    = EX_alu_out[1:0];
   assign w_mem_op = EX_valid & (EX_MemRead | EX_MemWrite);
   assign w_store  = EX_MemWrite;
   assign w_nonmem = EX_valid & ~(EX_MemRead | EX_MemWrite);

   always_comb begin
      w_legal    = 1'b0;
      w_misalign = 1'b0;
      if (w_store)
         w_legal = ~EX_funct3[2] & (EX_funct3[1:0] != 2'b11);
      else
         w_legal = (EX_funct3[1:0] != 2'b11) & ~(EX_funct3[2] & EX_funct3[1]);
      case (EX_funct3[1:0])
         2'b01:   w_misalign = w_off[0];
         2'b10:   w_misalign = (w_off != 2'b00);
         default: w_misalign = 1'b0;
      endcase
   end

   assign w_acc_fault = w_mem_op & (~w_legal | w_misalign);
   assign w_issue     = w_mem_op & ~w_acc_fault;

   always_comb begin
      w_be    = '0;
      w_wdata = '0;
      case (EX_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{EX_rs2_data[7:0]}};
         end
         2'b01: begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{EX_rs2_data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = EX_rs2_data;
         end
      endcase
   end

   assign w_shifted = DM_rdata >> {w_off, 3'b000};

   always_comb begin
      case (EX_funct3)
         3'b000:  w_load = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
         3'b101:  w_load = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
         default: w_load = w_shifted;
      endcase
   end

   // BUSY keeps the request up until ready; timeout drops it and releases the stall
   always_comb begin
      w_state_nx = r_state;
      w_wait_nx  = r_wait;
      w_req      = 1'b0;
      w_stall    = 1'b0;
      w_complete = 1'b0;
      w_timeout  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               w_req = 1'b1;
               if (DM_ready) begin
                  w_complete = 1'b1;
               end else begin
                  w_stall    = 1'b1;
                  w_state_nx = S_BUSY;
                  w_wait_nx  = '0;
               end
            end
         end
         S_BUSY: begin
            if (DM_ready) begin
               w_req      = 1'b1;
               w_complete = 1'b1;
               w_state_nx = S_IDLE;
            end else if (r_wait == LP_MAX_WAIT) begin
               w_timeout  = 1'b1;
               w_state_nx = S_IDLE;
            end else begin
               w_req     = 1'b1;
               w_stall   = 1'b1;
               w_wait_nx = r_wait + 8'd1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign w_fault = ((r_state == S_IDLE) & w_acc_fault) | w_timeout;

   // Combinational outputs are gated by reset so they fall without a clock
   assign DM_req    = rst & w_req;
   assign DM_we     = DM_req & w_store;
   assign DM_be     = (DM_req & w_store) ? w_be : '0;
   assign DM_addr   = DM_req ? {EX_alu_out[XLEN-1:2], 2'b00} : '0;
   assign DM_wdata  = (DM_req & w_store) ? w_wdata : '0;
   assign MEM_stall = rst & w_stall;
   assign MEM_fault = rst & w_fault;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_wait  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_wait  <= w_wait_nx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         MEM_MemtoReg <= 1'b0;
         MEM_RegWrite <= 1'b0;
         MEM_rd_data  <= '0;
         MEM_Dout     <= '0;
         MEM_rd_addr  <= '0;
      end else if (w_complete) begin
         MEM_MemtoReg <= EX_MemtoReg;
         MEM_RegWrite <= EX_RegWrite & ~w_store;
         MEM_rd_data  <= EX_alu_out;
         MEM_Dout     <= w_store ? '0 : w_load;
         MEM_rd_addr  <= EX_rd_addr;
      end else if ((r_state == S_IDLE) && w_nonmem) begin
         MEM_MemtoReg <= EX_MemtoReg;
         MEM_RegWrite <= EX_RegWrite;
         MEM_rd_data  <= EX_alu_out;
         MEM_Dout     <= '0;
         MEM_rd_addr  <= EX_rd_addr;
      end else begin
         MEM_MemtoReg <= 1'b0;
         MEM_RegWrite <= 1'b0;
         MEM_rd_data  <= '0;
         MEM_Dout     <= '0;
         MEM_rd_addr  <= '0;
      end
   end

endmodule
